pico_stream_router: RTL and testbench
=====================================

Name: pico_stream_router

Overview:
- Registered, parametrised successor of the combinational pico/camera/LCD data mux.
- Routes pico bus writes or camera pixels to the LCD through a valid/ready output register.
- Buffers SIMD results, or a loopback copy of LCD beats, in a readback FIFO that the pico drains with bus read strobes.
- Sits between the pico parallel bus, the camera port, the SIMD core and the LCD driver.

Parameters:
- DW, 8, data width of every data path.
- FIFO_DEPTH, 16, readback FIFO entries; must be a power of 2, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on pico_cs_n, pico_wr_n, pico_rd_n and pico_data_in.
- EMPTY_FILL, {DW{1'b1}}, value returned on a read from an empty FIFO.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- pico_cs_n  in  1  bus chip select, active low, asynchronous to clk.
- pico_wr_n  in  1  write strobe, active low, asynchronous.
- pico_rd_n  in  1  read strobe, active low, asynchronous.
- pico_data_in  in  DW  bus write data.
- pico_data_out  out  DW  bus read data, registered.
- pico_data_oe  out  1  drive enable for the top-level tristate.
- sel_poc  in  1  LCD source: 1 = camera, 0 = pico writes.
- sel_sod  in  1  FIFO source: 1 = SIMD, 0 = LCD loopback.
- cam_data  in  DW  camera pixel.
- cam_valid  in  1  camera pixel strobe; one beat per cycle high.
- simd_data  in  DW  SIMD result.
- simd_valid  in  1  SIMD result strobe.
- lcd_data  out  DW  LCD data.
- lcd_valid  out  1  LCD beat valid.
- lcd_ready  in  1  LCD accepts the beat.
- fifo_empty  out  1  readback FIFO empty.
- fifo_full  out  1  readback FIFO full.
- ovf_flag  out  1  sticky: a beat was dropped.
- clr_flags  in  1  clears ovf_flag.

Behaviour:
- Reset: pico_data_out = 0, pico_data_oe = 0, lcd_data = 0, lcd_valid = 0, ovf_flag = 0, FIFO pointers = 0 (fifo_empty = 1, fifo_full = 0). Synchroniser flops load 1 for the strobes and 0 for data. A reset mid-transfer discards all content.
- Sync: strobes and data pass through SYNC_STAGES flops.
  - wr_evt = 1-cycle pulse on a falling edge of synced wr_n while synced cs_n = 0.
  - rd_evt = the same for rd_n.
  - Write data is sampled from the synced data in the wr_evt cycle.
- LCD path:
  - src_beat = sel_poc ? cam_valid : wr_evt; src_data = the matching data.
  - If src_beat and (!lcd_valid or lcd_ready): lcd_data <= src_data and lcd_valid <= 1 on the next edge (latency 1 cycle from src_beat).
  - Else if lcd_valid and lcd_ready: lcd_valid <= 0.
  - If src_beat while lcd_valid and !lcd_ready: beat dropped, lcd_data held, ovf_flag <= 1.
  - lcd_data is stable while lcd_valid = 1 and lcd_ready = 0.
- FIFO push:
  - push_req = sel_sod ? simd_valid : (src_beat accepted by the LCD register); push data follows the same selection.
  - Pushed if not full, or if full and a pop occurs in the same cycle.
  - Otherwise dropped, with ovf_flag <= 1.
- FIFO pop:
  - On rd_evt: if not empty, pico_data_out <= head and the read pointer advances.
  - If empty: pico_data_out <= EMPTY_FILL, no pointer change, no flag set.
  - pico_data_out updates 1 cycle after rd_evt and holds until the next rd_evt.
- Simultaneous push and pop when empty: pop returns EMPTY_FILL; the pushed word is stored and the FIFO ends with 1 entry.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally.
  - fifo_empty = pointers equal.
  - fifo_full = MSBs differ and the rest are equal.
  - Both flags are registered consistently with the pointers.
- pico_data_oe = synced cs_n = 0 and synced rd_n = 0; combinational from the sync registers.
- ovf_flag: set has priority over clr_flags in the same cycle.
- sel_poc and sel_sod are sampled every cycle; switching them mid-stream affects only the next beat.

Test Plan:
- Reset, then sel_poc = 0, lcd_ready = 1, pico write 8'hA5 (cs_n = 0, wr_n pulse) -> lcd_data = 8'hA5 with lcd_valid high for 1 cycle, SYNC_STAGES+2 cycles after the wr_n fall; ovf_flag = 0.
- sel_poc = 1, lcd_ready = 0, cam_valid on 2 consecutive cycles with 8'h11 then 8'h22 -> lcd_data holds 8'h11; ovf_flag = 1; on lcd_ready = 1 the beat completes and clr_flags clears the flag.
- sel_sod = 1, 16 simd_valid beats 0..15 then a 17th beat 8'h10 -> fifo_full = 1, ovf_flag = 1; 16 pico reads return 0..15 in order, then fifo_empty = 1.
- Read with the FIFO empty -> pico_data_out = 8'hFF, pointers unchanged; pico_data_oe high only while cs_n and rd_n (synced) are both low.
- FIFO full, simd_valid coincident with rd_evt -> head returned, new word stored, fifo_full stays 1, ovf_flag = 0.
- Assert rst mid-stream with 5 entries queued and lcd_valid = 1 -> next cycle all outputs reach reset values and fifo_empty = 1.

Source files
------------

// File: rtl/pico_stream_router.sv
// pico_stream_router: registered router between the pico parallel bus, the
// camera port, the SIMD core and the LCD driver. Pico writes or camera pixels
// feed a valid/ready LCD output register. SIMD results, or a loopback copy of
// accepted LCD beats, fill a readback FIFO that the pico drains with bus reads.
module pico_stream_router #(
  parameter int              DW          = 8,
  parameter int              FIFO_DEPTH  = 16,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DW-1:0]   EMPTY_FILL  = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pico_cs_n,
  input  logic          pico_wr_n,
  input  logic          pico_rd_n,
  input  logic [DW-1:0] pico_data_in,
  output logic [DW-1:0] pico_data_out,
  output logic          pico_data_oe,
  input  logic          sel_poc,
  input  logic          sel_sod,
  input  logic [DW-1:0] cam_data,
  input  logic          cam_valid,
  input  logic [DW-1:0] simd_data,
  input  logic          simd_valid,
  output logic [DW-1:0] lcd_data,
  output logic          lcd_valid,
  input  logic          lcd_ready,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          ovf_flag,
  input  logic          clr_flags
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Synchroniser chains and bus event detection
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [DW-1:0]          r_data_sync [SYNC_STAGES];
  logic                   r_wr_prev;
  logic                   r_rd_prev;
  logic                   r_wr_evt;
  logic                   r_rd_evt;
  logic [DW-1:0]          r_wr_data;

  logic                   w_cs_s;
  logic                   w_wr_s;
  logic                   w_rd_s;
  logic [DW-1:0]          w_data_s;
  logic                   w_wr_fall;
  logic                   w_rd_fall;

  // LCD output register and sticky overflow flag
  logic [DW-1:0]          r_lcd_data;
  logic                   r_lcd_valid;
  logic                   r_ovf;

  logic                   w_src_beat;
  logic [DW-1:0]          w_src_data;
  logic                   w_lcd_take;
  logic                   w_lcd_drop;

  // Readback FIFO
  logic [DW-1:0]          r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic                   r_empty;
  logic                   r_full;
  logic [DW-1:0]          r_pico_out;

  logic                   w_push_req;
  logic [DW-1:0]          w_push_data;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_fifo_drop;
  logic [AW:0]            w_wr_ptr_nxt;
  logic [AW:0]            w_rd_ptr_nxt;

  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];
  assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // A strobe event is a high-to-low step of the synced strobe while chip select is low.
  assign w_wr_fall = r_wr_prev & ~w_wr_s & ~w_cs_s;
  assign w_rd_fall = r_rd_prev & ~w_rd_s & ~w_cs_s;

  // Bring the asynchronous bus into clk and turn strobe edges into 1-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register holding state is written with <= so all flops
      // update from the same pre-edge values; = here would chain the stages.
      r_cs_sync <= '1;
      r_wr_sync <= '1;
      r_rd_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
      r_wr_prev <= 1'b1;
      r_rd_prev <= 1'b1;
      r_wr_evt  <= 1'b0;
      r_rd_evt  <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_cs_sync[0]   <= pico_cs_n;
      r_wr_sync[0]   <= pico_wr_n;
      r_rd_sync[0]   <= pico_rd_n;
      r_data_sync[0] <= pico_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_wr_sync[i]   <= r_wr_sync[i-1];
        r_rd_sync[i]   <= r_rd_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_wr_prev <= w_wr_s;
      r_rd_prev <= w_rd_s;
      r_wr_evt  <= w_wr_fall;
      r_rd_evt  <= w_rd_fall;
      if (w_wr_fall) r_wr_data <= w_data_s;
    end
  end

  // Source selection for the LCD; a beat is taken when the register is free or draining.
  assign w_src_beat = sel_poc ? cam_valid : r_wr_evt;
  assign w_src_data = sel_poc ? cam_data  : r_wr_data;
  assign w_lcd_take = w_src_beat & (~r_lcd_valid | lcd_ready);
  assign w_lcd_drop = w_src_beat & r_lcd_valid & ~lcd_ready;

  // FIFO push/pop decisions; a full FIFO still accepts when the same cycle pops.
  assign w_push_req   = sel_sod ? simd_valid : w_lcd_take;
  assign w_push_data  = sel_sod ? simd_data  : w_src_data;
  assign w_pop        = r_rd_evt & ~r_empty;
  assign w_push       = w_push_req & (~r_full | w_pop);
  assign w_fifo_drop  = w_push_req & r_full & ~w_pop;
  assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

  // LCD valid/ready register plus the sticky drop flag (set wins over clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcd_data  <= '0;
      r_lcd_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_lcd_take) begin
        r_lcd_data  <= w_src_data;
        r_lcd_valid <= 1'b1;
      end else if (r_lcd_valid && lcd_ready) begin
        r_lcd_valid <= 1'b0;
      end
      if (w_lcd_drop || w_fifo_drop) r_ovf <= 1'b1;
      else if (clr_flags)            r_ovf <= 1'b0;
    end
  end

  // FIFO storage: written only on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are live, so stale contents are never observable.
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
  end

  // FIFO pointers with empty/full registered from the next-state pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    end
  end

  // Bus read data: head of the FIFO, or the fill pattern when nothing is queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pico_out <= '0;
    end else if (r_rd_evt) begin
      r_pico_out <= r_empty ? EMPTY_FILL : r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign pico_data_out = r_pico_out;
  assign pico_data_oe  = ~w_cs_s & ~w_rd_s;
  assign lcd_data      = r_lcd_data;
  assign lcd_valid     = r_lcd_valid;
  assign fifo_empty    = r_empty;
  assign fifo_full     = r_full;
  assign ovf_flag      = r_ovf;

endmodule

// File: tb/tb_pico_stream_router.sv
// Bench for pico_stream_router: directed bus/camera/SIMD stimulus, a queue-based
// reference model compared on every cycle, and literal expectations per scenario.
module tb_pico_stream_router;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int MAXH  = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          pico_cs_n, pico_wr_n, pico_rd_n;
  logic [DW-1:0] pico_data_in;
  logic [DW-1:0] pico_data_out;
  logic          pico_data_oe;
  logic          sel_poc, sel_sod;
  logic [DW-1:0] cam_data;
  logic          cam_valid;
  logic [DW-1:0] simd_data;
  logic          simd_valid;
  logic [DW-1:0] lcd_data;
  logic          lcd_valid;
  logic          lcd_ready;
  logic          fifo_empty, fifo_full, ovf_flag;
  logic          clr_flags;

  int n_vec = 0;
  int n_err = 0;

  pico_stream_router #(
    .DW(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .EMPTY_FILL(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .pico_cs_n(pico_cs_n), .pico_wr_n(pico_wr_n), .pico_rd_n(pico_rd_n),
    .pico_data_in(pico_data_in), .pico_data_out(pico_data_out),
    .pico_data_oe(pico_data_oe),
    .sel_poc(sel_poc), .sel_sod(sel_sod),
    .cam_data(cam_data), .cam_valid(cam_valid),
    .simd_data(simd_data), .simd_valid(simd_valid),
    .lcd_data(lcd_data), .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .ovf_flag(ovf_flag), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin history per posedge; a bus event is a high-to-low strobe step in the
  // history, seen by the router SYNC_STAGES+1 edges after it was first sampled.
  bit            cs_h [MAXH];
  bit            wr_h [MAXH];
  bit            rd_h [MAXH];
  logic [DW-1:0] d_h  [MAXH];
  int            n_edge = -1;

  function automatic bit cs_at(input int i); return (i < 0) ? 1'b1 : cs_h[i]; endfunction
  function automatic bit wr_at(input int i); return (i < 0) ? 1'b1 : wr_h[i]; endfunction
  function automatic bit rd_at(input int i); return (i < 0) ? 1'b1 : rd_h[i]; endfunction
  function automatic logic [DW-1:0] d_at(input int i); return (i < 0) ? '0 : d_h[i]; endfunction

  logic [DW-1:0] q[$];
  bit            m_lcd_valid = 0;
  logic [DW-1:0] m_lcd_data  = '0;
  logic [DW-1:0] m_out       = '0;
  bit            m_ovf       = 0;
  bit            m_oe        = 0;
  bit            m_live      = 0;

  bit            pb, rb, src, acc, drop, preq, popped;
  logic [DW-1:0] pd, sd, pushd;
  int            sz;

  always @(posedge clk) begin
    n_edge++;
    if (n_edge >= MAXH) begin
      $display("FAIL history_budget: got %0d edges, expected below %0d", n_edge, MAXH);
      $fatal(1, "history budget exceeded");
    end
    cs_h[n_edge] = pico_cs_n;
    wr_h[n_edge] = pico_wr_n;
    rd_h[n_edge] = pico_rd_n;
    d_h[n_edge]  = pico_data_in;
    if (rst) begin
      q.delete();
      m_lcd_valid = 0; m_lcd_data = '0; m_out = '0; m_ovf = 0; m_oe = 0;
    end else begin
      pb = wr_at(n_edge-SYNC-2) && !wr_at(n_edge-SYNC-1) && !cs_at(n_edge-SYNC-1);
      rb = rd_at(n_edge-SYNC-2) && !rd_at(n_edge-SYNC-1) && !cs_at(n_edge-SYNC-1);
      pd = d_at(n_edge-SYNC-1);
      src  = sel_poc ? cam_valid : pb;
      sd   = sel_poc ? cam_data  : pd;
      acc  = src && (!m_lcd_valid || lcd_ready);
      drop = src && !acc;
      if (acc) begin
        m_lcd_data  = sd;
        m_lcd_valid = 1;
      end else if (m_lcd_valid && lcd_ready) begin
        m_lcd_valid = 0;
      end
      preq  = sel_sod ? simd_valid : acc;
      pushd = sel_sod ? simd_data  : sd;
      sz     = q.size();
      popped = 0;
      if (rb) begin
        if (sz > 0) begin m_out = q.pop_front(); popped = 1; end
        else m_out = 8'hFF;
      end
      if (preq) begin
        if (sz < DEPTH || popped) q.push_back(pushd);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr_flags) m_ovf = 0;
      m_oe = !cs_at(n_edge-SYNC+1) && !rd_at(n_edge-SYNC+1);
    end
    m_live = 1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("lcd_valid",     lcd_valid,     m_lcd_valid);
      check("lcd_data",      lcd_data,      m_lcd_data);
      check("fifo_empty",    fifo_empty,    q.size() == 0);
      check("fifo_full",     fifo_full,     q.size() == DEPTH);
      check("ovf_flag",      ovf_flag,      m_ovf);
      check("pico_data_out", pico_data_out, m_out);
      check("pico_data_oe",  pico_data_oe,  m_oe);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pico_write(input logic [DW-1:0] d);
    pico_cs_n = 1'b0; pico_data_in = d; tick();
    pico_wr_n = 1'b0; tick(3);
    pico_wr_n = 1'b1; tick();
    pico_cs_n = 1'b1; tick(SYNC + 3);
  endtask

  task automatic pico_read();
    pico_cs_n = 1'b0; tick();
    pico_rd_n = 1'b0; tick(SYNC + 2);
    pico_rd_n = 1'b1; tick();
    pico_cs_n = 1'b1; tick(2);
  endtask

  task automatic simd_push(input logic [DW-1:0] d);
    simd_valid = 1'b1; simd_data = d; tick();
    simd_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_lcd_valid"},  lcd_valid,     0);
    check({tag, "_lcd_data"},   lcd_data,      0);
    check({tag, "_empty"},      fifo_empty,    1);
    check({tag, "_full"},       fifo_full,     0);
    check({tag, "_ovf"},        ovf_flag,      0);
    check({tag, "_out"},        pico_data_out, 0);
    check({tag, "_oe"},         pico_data_oe,  0);
  endtask

  initial begin
    rst = 1'b1;
    pico_cs_n = 1'b1; pico_wr_n = 1'b1; pico_rd_n = 1'b1; pico_data_in = '0;
    sel_poc = 1'b0; sel_sod = 1'b0; cam_data = '0; cam_valid = 1'b0;
    simd_data = '0; simd_valid = 1'b0; lcd_ready = 1'b1; clr_flags = 1'b0;
    tick(3);
    check_reset_state("reset");
    rst = 1'b0; tick(2);

    // Pico write to LCD: valid for one cycle, SYNC+2 edges after the wr_n fall.
    sel_poc = 1'b0; sel_sod = 1'b0; lcd_ready = 1'b1;
    pico_cs_n = 1'b0; pico_data_in = 8'hA5; tick();
    pico_wr_n = 1'b0;
    for (int k = 1; k <= SYNC + 3; k++) begin
      tick();
      if (k == 3) pico_wr_n = 1'b1;
      if (k == SYNC + 1) check("wr_lat_early", lcd_valid, 0);
      if (k == SYNC + 2) begin
        check("wr_lat_valid", lcd_valid, 1);
        check("wr_lat_data",  lcd_data,  8'hA5);
      end
      if (k == SYNC + 3) begin
        check("wr_one_cycle", lcd_valid, 0);
        check("wr_ovf",       ovf_flag,  0);
      end
    end
    pico_cs_n = 1'b1; tick(4);
    // Loopback copy of the accepted beat reads back through the FIFO.
    check("loop_not_empty", fifo_empty, 0);
    pico_read();
    check("loop_readback", pico_data_out, 8'hA5);
    check("loop_empty",    fifo_empty,    1);

    // Camera beats against a stalled LCD: second beat dropped, first held.
    sel_sod = 1'b1; sel_poc = 1'b1; lcd_ready = 1'b0;
    cam_valid = 1'b1; cam_data = 8'h11; tick();
    cam_data = 8'h22; tick();
    cam_valid = 1'b0; cam_data = '0;
    check("stall_data",  lcd_data,  8'h11);
    check("stall_valid", lcd_valid, 1);
    check("stall_ovf",   ovf_flag,  1);
    tick(2);
    check("stall_hold",  lcd_data,  8'h11);
    lcd_ready = 1'b1; tick();
    check("stall_done",  lcd_valid, 0);
    clr_flags = 1'b1; tick();
    clr_flags = 1'b0;
    check("ovf_cleared", ovf_flag, 0);

    // Fill from SIMD, overflow on the 17th beat, drain in order.
    for (int i = 0; i < DEPTH; i++) simd_push(8'(i));
    simd_push(8'h10);
    check("fill_full", fifo_full, 1);
    check("fill_ovf",  ovf_flag,  1);
    clr_flags = 1'b1; tick();
    clr_flags = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pico_read();
      check("drain_order", pico_data_out, 8'(i));
    end
    check("drain_empty", fifo_empty, 1);

    // Empty read returns the fill pattern; oe tracks synced cs_n/rd_n.
    pico_cs_n = 1'b0; tick();
    check("oe_cs_only", pico_data_oe, 0);
    pico_rd_n = 1'b0; tick(SYNC);
    check("oe_active", pico_data_oe, 1);
    tick(2);
    pico_rd_n = 1'b1;
    check("empty_read", pico_data_out, 8'hFF);
    tick(SYNC);
    check("oe_released", pico_data_oe, 0);
    pico_cs_n = 1'b1; tick(2);
    check("empty_still", fifo_empty, 1);
    check("empty_noovf", ovf_flag,   0);

    // Full FIFO: push coincident with a pop is accepted without overflow.
    for (int i = 0; i < DEPTH; i++) simd_push(8'h40 + 8'(i));
    check("full_again", fifo_full, 1);
    pico_cs_n = 1'b0; tick();
    pico_rd_n = 1'b0; tick(SYNC + 1);
    simd_valid = 1'b1; simd_data = 8'h99; tick();
    simd_valid = 1'b0;
    check("coinc_head", pico_data_out, 8'h40);
    check("coinc_full", fifo_full,     1);
    check("coinc_ovf",  ovf_flag,      0);
    pico_rd_n = 1'b1; tick();
    pico_cs_n = 1'b1; tick(2);
    for (int i = 1; i < DEPTH; i++) begin
      pico_read();
      check("coinc_drain", pico_data_out, 8'h40 + 8'(i));
    end
    pico_read();
    check("coinc_last", pico_data_out, 8'h99);
    check("coinc_empty", fifo_empty, 1);

    // Reset mid-stream with 5 entries queued and an LCD beat pending.
    sel_poc = 1'b1; lcd_ready = 1'b0;
    for (int i = 0; i < 5; i++) simd_push(8'h60 + 8'(i));
    cam_valid = 1'b1; cam_data = 8'h77; tick();
    cam_valid = 1'b0;
    check("pre_rst_valid", lcd_valid,  1);
    check("pre_rst_full",  fifo_empty, 0);
    rst = 1'b1; tick();
    check_reset_state("midrst");
    rst = 1'b0; lcd_ready = 1'b1; sel_poc = 1'b0; sel_sod = 1'b0; tick(2);

    // Normal traffic after reset: write loops back and reads out.
    pico_write(8'h3C);
    pico_read();
    check("post_rst_read", pico_data_out, 8'h3C);
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
